// File: rtl/channel_filter_error_pkg.sv
// Shared types and helpers for the channel filter residual/energy stage:
// fill-state encoding, saturation limits and the accumulator ceiling.
package channel_filter_error_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } fill_state_t;

    // Wide carriers so that saturation compares never overflow.
    typedef logic signed [31:0] error_wide_t;
    typedef logic [63:0]        energy_wide_t;

    localparam int code_delay_max = 3;

    function automatic error_wide_t sat_hi(input int bits);
        return error_wide_t'((32'sd1 <<< (bits - 1)) - 32'sd1);
    endfunction

    function automatic error_wide_t sat_lo(input int bits);
        return error_wide_t'(-(32'sd1 <<< (bits - 1)));
    endfunction

    function automatic energy_wide_t acc_max(input int bits);
        return (64'd1 << bits) - 64'd1;
    endfunction

endpackage

// File: rtl/channel_filter_error_lane.sv
// One lane: saturated residual register plus a saturating squared-error
// accumulator that is handed to the energy register at window completion.
module channel_filter_error_lane
    import channel_filter_error_pkg::*;
#(
    parameter int code_bw = 8,
    parameter int err_bw  = 9,
    parameter int acc_bw  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              acc_en,
    input  logic              win_done,
    input  logic              clear,
    input  logic [code_bw-1:0] code,
    input  logic [code_bw-1:0] est,
    output logic [err_bw-1:0]  est_error,
    output logic [acc_bw-1:0]  energy
);

    localparam int diff_bw = code_bw + 1;
    localparam int sq_bw   = 2 * err_bw;
    localparam int sum_bw  = ((acc_bw > sq_bw) ? acc_bw : sq_bw) + 1;

    logic signed [diff_bw-1:0] diff_s;
    error_wide_t               diff_w_s;
    logic [err_bw-1:0]         err_sat_s;
    logic signed [sq_bw-1:0]   sq_s;
    logic [sum_bw-1:0]         sum_s;
    logic [sum_bw-1:0]         ceil_s;
    logic [acc_bw-1:0]         acc_next_s;
    logic [err_bw-1:0]         est_error_r;
    logic [acc_bw-1:0]         acc_r;
    logic [acc_bw-1:0]         energy_r;

    // Residual with one guard bit, then clamp into the output range.
    always_comb begin
        diff_s   = $signed({code[code_bw-1], code}) - $signed({est[code_bw-1], est});
        diff_w_s = error_wide_t'(diff_s);
        if (diff_w_s > sat_hi(err_bw)) begin
            err_sat_s = err_bw'(sat_hi(err_bw));
        end else if (diff_w_s < sat_lo(err_bw)) begin
            err_sat_s = err_bw'(sat_lo(err_bw));
        end else begin
            err_sat_s = err_bw'(diff_w_s);
        end
    end

    // Square the registered residual and add with a ceiling instead of wrap.
    always_comb begin
        sq_s   = sq_bw'($signed(est_error_r)) * sq_bw'($signed(est_error_r));
        sum_s  = sum_bw'(acc_r) + sum_bw'($unsigned(sq_s));
        ceil_s = sum_bw'(acc_max(acc_bw));
        if (sum_s > ceil_s) begin
            acc_next_s = acc_bw'(acc_max(acc_bw));
        end else begin
            acc_next_s = acc_bw'(sum_s);
        end
    end

    // Residual, accumulator and window energy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            est_error_r <= '0;
            acc_r       <= '0;
            energy_r    <= '0;
        end else begin
            if (accept) begin
                est_error_r <= err_sat_s;
            end
            if (clear) begin
                acc_r <= '0;
            end else if (win_done) begin
                energy_r <= acc_next_s;
                acc_r    <= '0;
            end else if (acc_en) begin
                acc_r <= acc_next_s;
            end
        end
    end

    assign est_error = est_error_r;
    assign energy    = energy_r;

endmodule

// File: rtl/channel_filter_error.sv
// Aligns ADC codes with the channel filter estimate, emits per-lane residuals
// and reports windowed squared-error energy for channel-estimate monitoring.
module channel_filter_error
    import channel_filter_error_pkg::*;
#(
    parameter int width              = 16,
    parameter int est_code_bitwidth  = 8,
    parameter int est_error_bitwidth = 9,
    parameter int code_delay         = 2,
    parameter int acc_bitwidth       = 24,
    parameter int window_bitwidth    = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    input  logic [width-1:0][est_code_bitwidth-1:0]          codes,
    input  logic [width-1:0][est_code_bitwidth-1:0]          est_code,
    input  logic                                            clear,
    input  logic [window_bitwidth-1:0]                       window_len,
    output logic [width-1:0][est_error_bitwidth-1:0]         est_error,
    output logic                                            out_valid,
    output logic [width-1:0][acc_bitwidth-1:0]               energy,
    output logic                                            energy_valid
);

    localparam int         dly_slots = (code_delay > 0) ? code_delay : 1;
    localparam logic [2:0] cd3       = 3'(code_delay);

    logic [width-1:0][est_code_bitwidth-1:0] dly_r [dly_slots];
    logic [width-1:0][est_code_bitwidth-1:0] aligned_s;
    fill_state_t                state_r, state_n;
    logic [1:0]                 fill_r, fill_n;
    logic [2:0]                 fill_inc_s;
    logic                       accept_s;
    logic                       out_valid_r;
    logic                       energy_valid_r;
    logic [window_bitwidth-1:0] cnt_r;
    logic [window_bitwidth-1:0] win_len_r;
    logic [window_bitwidth-1:0] eff_len_s;
    logic [window_bitwidth:0]   cnt_inc_s;
    logic                       win_done_s;
    logic                       acc_en_s;

    // Code delay line, advanced once per incoming frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < dly_slots; k++) begin
                dly_r[k] <= '0;
            end
        end else if (in_valid) begin
            dly_r[0] <= codes;
            for (int k = 1; k < dly_slots; k++) begin
                dly_r[k] <= dly_r[k-1];
            end
        end
    end

    if (code_delay == 0) begin : g_nodly
        assign aligned_s = codes;
    end else begin : g_dly
        assign aligned_s = dly_r[dly_slots-1];
    end

    // Fill/run sequencing: frames during fill only prime the delay line.
    always_comb begin
        state_n    = state_r;
        fill_n     = fill_r;
        accept_s   = 1'b0;
        fill_inc_s = {1'b0, fill_r} + 3'd1;
        case (state_r)
            ST_FILL: begin
                if (!in_valid) begin
                    state_n = ST_FILL;
                end else if (cd3 == 3'd0) begin
                    accept_s = 1'b1;
                    state_n  = ST_RUN;
                end else if (fill_inc_s >= cd3) begin
                    fill_n  = fill_inc_s[1:0];
                    state_n = ST_RUN;
                end else begin
                    fill_n = fill_inc_s[1:0];
                end
            end
            ST_RUN: begin
                accept_s = in_valid;
            end
            default: begin
                state_n = ST_FILL;
            end
        endcase
    end

    // Window length is latched on the first frame of each window.
    always_comb begin
        if (cnt_r != '0) begin
            eff_len_s = win_len_r;
        end else if (window_len == '0) begin
            eff_len_s = window_bitwidth'(1);
        end else begin
            eff_len_s = window_len;
        end
        cnt_inc_s  = {1'b0, cnt_r} + (window_bitwidth+1)'(1);
        acc_en_s   = out_valid_r && !clear;
        win_done_s = acc_en_s && (cnt_inc_s == {1'b0, eff_len_s});
    end

    // Control registers: fill state, frame valid and window bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_FILL;
            fill_r         <= 2'd0;
            out_valid_r    <= 1'b0;
            energy_valid_r <= 1'b0;
            cnt_r          <= '0;
            win_len_r      <= '0;
        end else begin
            state_r        <= state_n;
            fill_r         <= fill_n;
            out_valid_r    <= accept_s;
            energy_valid_r <= win_done_s;
            if (clear || win_done_s) begin
                cnt_r <= '0;
            end else if (out_valid_r) begin
                cnt_r <= cnt_inc_s[window_bitwidth-1:0];
                if (cnt_r == '0) begin
                    win_len_r <= eff_len_s;
                end
            end
        end
    end

    for (genvar i = 0; i < width; i++) begin : g_lane
        channel_filter_error_lane #(
            .code_bw (est_code_bitwidth),
            .err_bw  (est_error_bitwidth),
            .acc_bw  (acc_bitwidth)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .accept    (accept_s),
            .acc_en    (acc_en_s),
            .win_done  (win_done_s),
            .clear     (clear),
            .code      (aligned_s[i]),
            .est       (est_code[i]),
            .est_error (est_error[i]),
            .energy    (energy[i])
        );
    end

    assign out_valid    = out_valid_r;
    assign energy_valid = energy_valid_r;

endmodule

// File: tb/tb_channel_filter_error.sv
// Directed and randomized checks of channel_filter_error against a frame-level
// reference model (history queue of codes, integer accumulators).
module tb_channel_filter_error;

    localparam int W   = 4;
    localparam int CB  = 8;
    localparam int EB  = 8;
    localparam int CD  = 2;
    localparam int AB  = 16;
    localparam int WB  = 16;
    localparam int AMX = 65535;

    typedef logic [W-1:0][CB-1:0] frame_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    frame_t             codes;
    frame_t             est_code;
    logic               clear;
    logic [WB-1:0]      window_len;
    logic [W-1:0][EB-1:0] est_error;
    logic               out_valid;
    logic [W-1:0][AB-1:0] energy;
    logic               energy_valid;

    channel_filter_error #(
        .width(W), .est_code_bitwidth(CB), .est_error_bitwidth(EB),
        .code_delay(CD), .acc_bitwidth(AB), .window_bitwidth(WB)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .codes(codes),
        .est_code(est_code), .clear(clear), .window_len(window_len),
        .est_error(est_error), .out_valid(out_valid), .energy(energy),
        .energy_valid(energy_valid)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    frame_t hist[$];
    int     m_err[W];
    int     m_acc[W];
    int     m_en[W];
    int     m_cnt, m_len;
    logic   m_ov, m_ev;

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic iv, input logic clr);
        int a, e;
        if (r) begin
            hist.delete();
            m_ov = 1'b0; m_ev = 1'b0; m_cnt = 0; m_len = 0;
            for (int i = 0; i < W; i++) begin
                m_err[i] = 0; m_acc[i] = 0; m_en[i] = 0;
            end
        end else begin
            m_ev = 1'b0;
            if (clr) begin
                m_cnt = 0;
                for (int i = 0; i < W; i++) m_acc[i] = 0;
            end else if (m_ov) begin
                if (m_cnt == 0) m_len = (window_len == 16'd0) ? 1 : int'(window_len);
                for (int i = 0; i < W; i++) begin
                    m_acc[i] = m_acc[i] + m_err[i] * m_err[i];
                    if (m_acc[i] > AMX) m_acc[i] = AMX;
                end
                m_cnt++;
                if (m_cnt == m_len) begin
                    for (int i = 0; i < W; i++) begin
                        m_en[i] = m_acc[i]; m_acc[i] = 0;
                    end
                    m_cnt = 0;
                    m_ev  = 1'b1;
                end
            end
            m_ov = 1'b0;
            if (iv) begin
                if (hist.size() >= CD) begin
                    for (int i = 0; i < W; i++) begin
                        a = int'($signed(hist[hist.size()-CD][i]));
                        e = int'($signed(est_code[i]));
                        m_err[i] = sat(a - e);
                    end
                    m_ov = 1'b1;
                end
                hist.push_back(codes);
                if (hist.size() > CD) void'(hist.pop_front());
            end
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic clr);
        logic [W-1:0][EB-1:0] xe;
        logic [W-1:0][AB-1:0] xn;
        rst = r; in_valid = iv; clear = clr;
        model(r, iv, clr);
        @(posedge clk);
        #1;
        for (int i = 0; i < W; i++) begin
            xe[i] = EB'(m_err[i]);
            xn[i] = AB'(m_en[i]);
        end
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("energy_valid", 64'(energy_valid), 64'(m_ev));
        check("est_error", 64'(est_error), 64'(xe));
        check("energy", 64'(energy), 64'(xn));
    endtask

    task automatic set_frame(input int c, input int e);
        for (int i = 0; i < W; i++) begin
            codes[i]    = CB'(c);
            est_code[i] = CB'(e);
        end
    endtask

    // Two frames of a code to fill the delay line, then a clearing idle cycle.
    task automatic prime(input int c);
        set_frame(c, 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [63:0] pat;
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0; window_len = 16'd4;
        set_frame(0, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Alignment: third frame compares code 10 with estimate 10
        set_frame(10, 0); step(1'b0, 1'b1, 1'b0);
        set_frame(20, 0); step(1'b0, 1'b1, 1'b0);
        set_frame(30, 10); step(1'b0, 1'b1, 1'b0);
        check("align_valid", 64'(out_valid), 64'd1);
        check("align_err", 64'(est_error), 64'd0);

        // Residual saturation at both rails
        set_frame(127, 0);   step(1'b0, 1'b1, 1'b0);
        set_frame(-128, 0);  step(1'b0, 1'b1, 1'b0);
        set_frame(0, -128);  step(1'b0, 1'b1, 1'b0);
        pat = 64'(32'h7F7F_7F7F);
        check("sat_pos", 64'(est_error), pat);
        set_frame(0, 127);   step(1'b0, 1'b1, 1'b0);
        pat = 64'(32'h8080_8080);
        check("sat_neg", 64'(est_error), pat);

        // Window of 4 with constant error 3
        window_len = 16'd4;
        prime(3);
        for (int j = 1; j <= 9; j++) begin
            step(1'b0, 1'b1, 1'b0);
            if (j == 5 || j == 9) begin
                check("win4_pulse", 64'(energy_valid), 64'd1);
                pat = {16'd36, 16'd36, 16'd36, 16'd36};
                check("win4_energy", 64'(energy), pat);
            end
        end

        // window_len 0 behaves as 1
        window_len = 16'd0;
        prime(5);
        for (int j = 1; j <= 4; j++) begin
            step(1'b0, 1'b1, 1'b0);
            if (j >= 2) check("win0_pulse", 64'(energy_valid), 64'd1);
        end

        // Accumulator ceiling: 5 x 127^2 exceeds 16 bits
        window_len = 16'd5;
        prime(127);
        for (int j = 1; j <= 6; j++) step(1'b0, 1'b1, 1'b0);
        pat = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        check("acc_sat", 64'(energy), pat);

        // Clear on completion cycle suppresses the pulse
        window_len = 16'd4;
        prime(2);
        for (int j = 1; j <= 4; j++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("clr_no_pulse", 64'(energy_valid), 64'd0);

        // Reset mid-window restarts fill
        set_frame(7, 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 4; j++) step(1'b0, 1'b1, 1'b0);

        // Randomized traffic
        for (int j = 0; j < 600; j++) begin
            for (int i = 0; i < W; i++) begin
                codes[i]    = CB'($urandom);
                est_code[i] = CB'($urandom);
            end
            if ($urandom_range(0, 19) == 0) window_len = WB'($urandom_range(0, 6));
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 24) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
